// File: rtl/array_scan_pkg.sv
// ============================================================================
// Module      : array_scan_pkg
// Description : Shared definitions for the array scan reader: default
//               geometry, scan FSM state encoding, the value set that flags
//               a scanned entry, and the two value sets used by the optional
//               first-pair check (ARRAY_SCAN_PAIR_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package array_scan_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  // Entries whose value is in this set are presented with out_match=1.
  localparam int MATCH_SET_SIZE = 5;
  localparam int MATCH_SET [MATCH_SET_SIZE] = '{0, 10, 20, 30, 40};

  // First-pair check: entry 0 must be in PAIR0_SET, entry 1 in PAIR1_SET.
  localparam int PAIR_SET_SIZE = 2;
  localparam int PAIR0_SET [PAIR_SET_SIZE] = '{0, 1};
  localparam int PAIR1_SET [PAIR_SET_SIZE] = '{2, 3};

endpackage

`default_nettype wire

// File: rtl/set_match.sv
// ============================================================================
// Module      : set_match
// Description : Combinational set membership test. o_hit is high when
//               i_value equals any of the N WIDTH-bit entries in i_set.
// Ports       : i_value - value under test
//               i_set   - packed list of N set members
//               o_hit   - 1 when i_value is a member
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_match #(
  parameter int WIDTH = 8,
  parameter int N     = 1
) (
  input  logic [WIDTH-1:0]        i_value,
  input  logic [N-1:0][WIDTH-1:0] i_set,
  output logic                    o_hit
);

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_value == i_set[i]) begin
        o_hit = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_scan_reader.sv
// ============================================================================
// Module      : array_scan_reader
// Description : Scans array entries 0..DEPTH-1 on request. Each entry is
//               read (ISSUE), captured one cycle later (CAPTURE) and held on
//               a valid/ready output (PRESENT) together with a flag telling
//               whether it belongs to the match set. Matches accepted
//               downstream are counted; done pulses once per scan.
//               Optional macro ARRAY_SCAN_PAIR_CHECK_EN adds output
//               pair_match, registered at scan end from entries 0 and 1.
// Ports       : clk, rst (async, active low)
//               start                      - scan request (ignored when busy)
//               rd_en, rd_addr, rd_data    - array read port (1-cycle latency)
//               out_valid, out_ready,
//               out_data, out_match        - scanned entry stream
//               busy, done, match_count    - status
//               pair_match                 - only with ARRAY_SCAN_PAIR_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_scan_reader
  import array_scan_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rd_en,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [WIDTH-1:0]         rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_match,
  output logic                     busy,
  output logic                     done,
`ifdef ARRAY_SCAN_PAIR_CHECK_EN
  output logic                     pair_match,
`endif
  output logic [$clog2(DEPTH):0]   match_count
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [AW:0]     MAX_COUNT = (AW + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q,   ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic              match_q, match_d;

  // --------------------------------------------------------------------------
  // Match-set membership of the incoming read data
  // --------------------------------------------------------------------------
  logic [MATCH_SET_SIZE-1:0][WIDTH-1:0] match_set;
  logic                                 rd_hit;

  for (genvar gi = 0; gi < MATCH_SET_SIZE; gi++) begin : g_match_set
    assign match_set[gi] = WIDTH'(MATCH_SET[gi]);
  end

  set_match #(
    .WIDTH (WIDTH),
    .N     (MATCH_SET_SIZE)
  ) u_match (
    .i_value (rd_data),
    .i_set   (match_set),
    .o_hit   (rd_hit)
  );

  wire handshake = (state_q == ST_PRESENT) && out_ready;
  wire accept    = (state_q == ST_IDLE) && start;

`ifdef ARRAY_SCAN_PAIR_CHECK_EN
  // --------------------------------------------------------------------------
  // First-pair check: entry 0 / entry 1 membership is sampled as each is
  // captured and combined into pair_match when the scan finishes.
  // --------------------------------------------------------------------------
  logic [PAIR_SET_SIZE-1:0][WIDTH-1:0] pair0_set, pair1_set;
  logic pair0_hit, pair1_hit;
  logic pair0_q, pair0_d;
  logic pair1_q, pair1_d;
  logic pair_q,  pair_d;

  for (genvar gp = 0; gp < PAIR_SET_SIZE; gp++) begin : g_pair_set
    assign pair0_set[gp] = WIDTH'(PAIR0_SET[gp]);
    assign pair1_set[gp] = WIDTH'(PAIR1_SET[gp]);
  end

  set_match #(
    .WIDTH (WIDTH),
    .N     (PAIR_SET_SIZE)
  ) u_pair0 (
    .i_value (rd_data),
    .i_set   (pair0_set),
    .o_hit   (pair0_hit)
  );

  set_match #(
    .WIDTH (WIDTH),
    .N     (PAIR_SET_SIZE)
  ) u_pair1 (
    .i_value (rd_data),
    .i_set   (pair1_set),
    .o_hit   (pair1_hit)
  );

  always_comb begin
    pair0_d = pair0_q;
    pair1_d = pair1_q;
    pair_d  = pair_q;
    if (accept) begin
      pair0_d = 1'b0;
      pair1_d = 1'b0;
      pair_d  = 1'b0;
    end
    if (state_q == ST_CAPTURE && ptr_q == AW'(0)) begin
      pair0_d = pair0_hit;
    end
    if (state_q == ST_CAPTURE && ptr_q == AW'(1)) begin
      pair1_d = pair1_hit;
    end
    if (state_q == ST_FINISH) begin
      pair_d = pair0_q & pair1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair0_q <= 1'b0;
      pair1_q <= 1'b0;
      pair_q  <= 1'b0;
    end else begin
      pair0_q <= pair0_d;
      pair1_q <= pair1_d;
      pair_q  <= pair_d;
    end
  end

  assign pair_match = pair_q;
`endif

  // --------------------------------------------------------------------------
  // Scan FSM: next state and datapath updates
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    data_d  = data_q;
    match_d = match_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d  = rd_data;
        match_d = rd_hit;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          // Saturation guard only; a full scan of matches reaches DEPTH exactly.
          if (match_q && count_q != MAX_COUNT) begin
            count_d = count_q + 1'b1;
          end
          ptr_d   = ptr_q + 1'b1;
          state_d = (ptr_q == LAST_PTR) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      data_q  <= data_d;
      match_q <= match_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign rd_en       = (state_q == ST_ISSUE);
  assign rd_addr     = ptr_q;
  assign out_valid   = (state_q == ST_PRESENT);
  assign out_data    = data_q;
  assign out_match   = match_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign match_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_array_scan_reader.sv
// ============================================================================
// Module      : tb_array_scan_reader
// Description : Self-checking bench for array_scan_reader. A table of scan
//               scenarios (array contents, output stall, mid-scan start) is
//               applied in a loop; reset, start-in-FINISH and the optional
//               pair check (ARRAY_SCAN_PAIR_CHECK_EN) are hand sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_array_scan_reader;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_match;
  logic             busy;
  logic             done;
  logic [AW:0]      match_count;
`ifdef ARRAY_SCAN_PAIR_CHECK_EN
  logic             pair_match;
`endif

  array_scan_reader #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_match   (out_match),
    .busy        (busy),
    .done        (done),
`ifdef ARRAY_SCAN_PAIR_CHECK_EN
    .pair_match  (pair_match),
`endif
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  // Array model: read data valid one cycle after rd_en.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_val(input int mode, input logic [7:0] fill, input int i);
    case (mode)
      0:       return 8'(i * 10);
      1:       return fill;
      default: return 8'(i * 5);
    endcase
  endfunction

  task automatic fill_mem(input int mode, input logic [7:0] fill);
    for (int i = 0; i < DEPTH; i++) mem[i] = gen_val(mode, fill, i);
  endtask

  logic [WIDTH-1:0] obs_data  [DEPTH];
  logic             obs_match [DEPTH];

  // One full scan. k counts rising edges since the start-accepting edge.
  task automatic do_scan(input int stall_entry, input int stall_len, input int poke_entry,
                         output int n_out, output int done_at, output int n_done,
                         output int n_rd, output int stall_err, output int cnt_at_done,
                         output int first_addr);
    int stall_left;
    int cnt_before;
    n_out = 0; done_at = -1; n_done = 0; n_rd = 0; stall_err = 0;
    cnt_at_done = -1; first_addr = -1; stall_left = stall_len; cnt_before = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (rd_en) begin
        if (n_rd == 0) first_addr = int'(rd_addr);
        n_rd++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k;
          cnt_at_done = int'(match_count);
        end
      end
      start = 1'b0;
      if (out_valid) begin
        if (n_out == stall_entry && stall_left > 0) begin
          if (stall_left == stall_len) cnt_before = int'(match_count);
          else if (out_data !== mem[stall_entry] || int'(match_count) != cnt_before) stall_err++;
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (n_out < DEPTH) begin
            obs_data[n_out]  = out_data;
            obs_match[n_out] = out_match;
          end
          if (n_out == poke_entry) start = 1'b1;
          n_out++;
        end
      end else begin
        // out_ready wiggles outside PRESENT; it must not disturb the scan.
        out_ready = (k % 2 == 0);
      end
      if (done_at >= 0 && k > done_at + 2) break;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  typedef struct {
    int          mode;
    logic [7:0]  fill;
    int          stall_entry;
    int          stall_len;
    int          poke;
    int          exp_count;
    logic [15:0] exp_mask;
    int          exp_done_at;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n_out, done_at, n_done, n_rd, stall_err, cnt_at_done, first_addr, hs;
    bit seen;

    vecs[0] = '{0, 8'h00, -1, 0, -1,  5, 16'h001F, 48};
    vecs[1] = '{0, 8'h00,  3, 5, -1,  5, 16'h001F, 53};
    vecs[2] = '{0, 8'h00, -1, 0,  7,  5, 16'h001F, 48};
    vecs[3] = '{1, 8'hFF, -1, 0, -1,  0, 16'h0000, 48};
    vecs[4] = '{1, 8'd20, -1, 0, -1, 16, 16'hFFFF, 48};
    vecs[5] = '{2, 8'h00, -1, 0, -1,  5, 16'h0155, 48};

    // ---- reset values ----
    fill_mem(0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_match_count", match_count, 0);

    // ---- first start accepted on the first edge after reset release ----
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_start_busy", busy, 1);
    chk("first_start_rd_en", rd_en, 1);
    chk("first_start_rd_addr", rd_addr, 0);

    // ---- reset asserted while entry 9 is presented ----
    hs = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (hs == 9) begin
          seen = 1'b1;
          break;
        end
        hs++;
      end
    end
    chk("entry9_reached", seen, 1);
    chk("entry9_data", out_data, 90);
    #2 rst = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_rd_addr", rd_addr, 0);
    chk("midreset_match_count", match_count, 0);
    chk("midreset_out_match", out_match, 0);
    @(negedge clk);
    rst = 1'b1;

    // ---- table-driven scans ----
    for (int v = 0; v < 6; v++) begin
      fill_mem(vecs[v].mode, vecs[v].fill);
      do_scan(vecs[v].stall_entry, vecs[v].stall_len, vecs[v].poke,
              n_out, done_at, n_done, n_rd, stall_err, cnt_at_done, first_addr);
      chk($sformatf("v%0d_first_addr", v), first_addr, 0);
      chk($sformatf("v%0d_n_out", v), n_out, DEPTH);
      chk($sformatf("v%0d_n_rd", v), n_rd, DEPTH);
      chk($sformatf("v%0d_n_done", v), n_done, 1);
      chk($sformatf("v%0d_done_at", v), done_at, vecs[v].exp_done_at);
      chk($sformatf("v%0d_count_at_done", v), cnt_at_done, vecs[v].exp_count);
      chk($sformatf("v%0d_stall_err", v), stall_err, 0);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_idle_count", v), match_count, vecs[v].exp_count);
      for (int i = 0; i < DEPTH; i++) begin
        chk($sformatf("v%0d_data%0d", v, i), obs_data[i], gen_val(vecs[v].mode, vecs[v].fill, i));
        chk($sformatf("v%0d_match%0d", v, i), obs_match[i], vecs[v].exp_mask[i]);
      end
    end

    // ---- start held high through FINISH: accepted only in the next IDLE ----
    // Previous scan left match_count=5.
    fill_mem(0, 8'h00);
    start = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_start_done_seen", seen, 1);
    chk("hold_start_count_at_done", match_count, 5);
    @(negedge clk);
    chk("finish_start_ignored_busy", busy, 0);
    chk("finish_start_ignored_count", match_count, 5);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_accepted_busy", busy, 1);
    chk("idle_start_count_cleared", match_count, 0);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold_start_scan_end", seen, 1);
    chk("hold_start_scan_count", match_count, 5);

`ifdef ARRAY_SCAN_PAIR_CHECK_EN
    // ---- first-pair check ----
    fill_mem(1, 8'h00);
    mem[0] = 8'd1;
    mem[1] = 8'd3;
    do_scan(-1, 0, -1, n_out, done_at, n_done, n_rd, stall_err, cnt_at_done, first_addr);
    chk("pair_1_3", pair_match, 1);
    mem[1] = 8'd4;
    do_scan(-1, 0, -1, n_out, done_at, n_done, n_rd, stall_err, cnt_at_done, first_addr);
    chk("pair_1_4", pair_match, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
